// File: rtl/slc3_mem_responder.sv
// Cycle-accurate model of the SLC-3 board SRAM: strobe-counted reads and writes
// against a 2^DEPTH_BITS x 16-bit array with byte enables and address aliasing.
module slc3_mem_responder #(
  parameter int DEPTH_BITS = 8,
  parameter int READ_LAT   = 3,
  parameter int WRITE_LAT  = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic        Busy
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [2:0] RD_LAST = 3'(READ_LAT - 1);
  localparam logic [2:0] WR_LAST = 3'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              count_q, count_d;
  logic [DEPTH_BITS-1:0]   addr_q, addr_d;
  logic                    ub_en_q, ub_en_d;
  logic                    lb_en_q, lb_en_d;
  logic [15:0]             data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic [15:0]             mem_q [DEPTH];
  logic [15:0]             mem_rdata;
  logic                    mem_wr;
  logic [DEPTH_BITS-1:0]   mem_addr;
  logic                    mem_ub_en;
  logic                    mem_lb_en;

  logic                    wr_strobe;
  logic                    rd_strobe;
  logic [DEPTH_BITS-1:0]   addr_in;
  logic                    unused_addr_hi;

  // Writes win over reads when both strobes are low; a read also needs WE high.
  assign wr_strobe      = !Mem_CE && !Mem_WE;
  assign rd_strobe      = !Mem_CE && !Mem_OE;
  assign addr_in        = ADDR[DEPTH_BITS-1:0];
  assign unused_addr_hi = ^ADDR[19:DEPTH_BITS];
  assign mem_rdata      = mem_q[addr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    ub_en_d   = ub_en_q;
    lb_en_d   = lb_en_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    mem_wr    = 1'b0;
    mem_addr  = addr_q;
    mem_ub_en = ub_en_q;
    mem_lb_en = lb_en_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (wr_strobe) begin
          addr_d  = addr_in;
          ub_en_d = !Mem_UB;
          lb_en_d = !Mem_LB;
          count_d = 3'd1;
          if (WRITE_LAT == 1) begin
            mem_wr    = 1'b1;
            mem_addr  = addr_in;
            mem_ub_en = !Mem_UB;
            mem_lb_en = !Mem_LB;
            state_d   = WR_DONE;
          end else begin
            state_d = WR_WAIT;
            busy_d  = 1'b1;
          end
        end else if (rd_strobe) begin
          addr_d  = addr_in;
          count_d = 3'd1;
          state_d = RD_WAIT;
          busy_d  = 1'b1;
        end
      end

      RD_WAIT: begin
        if (!rd_strobe) begin
          state_d = IDLE;
          count_d = 3'd0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + 3'd1;
          if (count_q == RD_LAST) begin
            data_d  = mem_rdata;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = RD_DONE;
          end
        end
      end

      RD_DONE: begin
        if (!rd_strobe) begin
          state_d = IDLE;
          count_d = 3'd0;
          valid_d = 1'b0;
        end
      end

      WR_WAIT: begin
        if (!wr_strobe) begin
          state_d = IDLE;
          count_d = 3'd0;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + 3'd1;
          if (count_q == WR_LAST) begin
            mem_wr  = 1'b1;
            busy_d  = 1'b0;
            state_d = WR_DONE;
          end
        end
      end

      WR_DONE: begin
        // Strobes held past the commit never cause a second write.
        if (!wr_strobe) begin
          state_d = IDLE;
          count_d = 3'd0;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = 3'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (Reset) begin
      mem_wr = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      addr_q  <= '0;
      ub_en_q <= 1'b0;
      lb_en_q <= 1'b0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      ub_en_q <= ub_en_d;
      lb_en_q <= lb_en_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: the array has no reset; contents survive Reset and are undefined until written.
  always_ff @(posedge Clk) begin
    if (mem_wr) begin
      if (mem_ub_en) mem_q[mem_addr][15:8] <= Data_from_CPU[15:8];
      if (mem_lb_en) mem_q[mem_addr][7:0]  <= Data_from_CPU[7:0];
    end
  end

  assign Data_to_CPU = data_q;
  assign Data_valid  = valid_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: table of accesses with a read-data
// scoreboard, plus hand-written reset-during-access sequences.
module tb_slc3_mem_responder;

  localparam int DB = 8;
  localparam int RL = 3;
  localparam int WL = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Data_valid;
  logic        Busy;

  slc3_mem_responder #(.DEPTH_BITS(DB), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_CE        (Mem_CE),
    .Mem_UB        (Mem_UB),
    .Mem_LB        (Mem_LB),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Data_valid    (Data_valid),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          wr;
    bit          oe_too;
    logic [19:0] addr;
    logic [15:0] data;
    bit          ub_n;
    bit          lb_n;
    int          cycles;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        tbl [15];
  logic [15:0] sb [$];
  logic [15:0] last_rd;
  int          n_pass  = 0;
  int          n_total = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit wr, input bit oe_too, input logic [19:0] addr,
                              input logic [15:0] data, input bit ub_n, input bit lb_n,
                              input int cycles, input logic [15:0] exp_data);
    vec_t v;
    v.wr = wr; v.oe_too = oe_too; v.addr = addr; v.data = data;
    v.ub_n = ub_n; v.lb_n = lb_n; v.cycles = cycles; v.exp_data = exp_data;
    return v;
  endfunction

  // Scoreboard consumer: every rising Data_valid must match the oldest queued read.
  always @(negedge Clk) begin
    if (Data_valid && !prev_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("read_data", Data_to_CPU, sb.pop_front());
    end
    prev_valid = Data_valid;
  end

  task automatic release_strobes();
    Mem_CE = 1'b1; Mem_WE = 1'b1; Mem_OE = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge Clk); #1;
    Mem_CE = 1'b0;
    Mem_WE = v.wr ? 1'b0 : 1'b1;
    Mem_OE = (v.wr && !v.oe_too) ? 1'b1 : 1'b0;
    ADDR   = v.addr;
    Mem_UB = v.ub_n;
    Mem_LB = v.lb_n;
    Data_from_CPU = (v.wr && WL > 1) ? ~v.data : v.data;
    if (!v.wr && v.cycles >= RL) sb.push_back(v.exp_data);
    for (int i = 1; i <= v.cycles; i++) begin
      @(posedge Clk); #1;
      ADDR   = ~v.addr;
      Mem_UB = ~v.ub_n;
      Mem_LB = ~v.lb_n;
      if (v.wr) begin
        check({tag, " wr_busy"}, Busy, 32'(i < WL));
        check({tag, " wr_valid"}, Data_valid, 32'd0);
        Data_from_CPU = (i == WL - 1) ? v.data : ~v.data;
      end else begin
        check({tag, " rd_busy"}, Busy, 32'(i < RL));
        check({tag, " rd_valid"}, Data_valid, 32'(i >= RL));
      end
    end
    release_strobes();
    @(posedge Clk); #1;
    check({tag, " idle_busy"}, Busy, 32'd0);
    check({tag, " idle_valid"}, Data_valid, 32'd0);
    if (!v.wr) begin
      if (v.cycles >= RL) last_rd = v.exp_data;
      check({tag, " data_hold"}, Data_to_CPU, last_rd);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 20'h00005, 16'hABCD, 0, 0, 3, 16'h0000);
    tbl[1]  = mk(0, 0, 20'h00005, 16'h0000, 0, 0, 3, 16'hABCD);
    tbl[2]  = mk(1, 0, 20'h00005, 16'h1234, 1, 0, 3, 16'h0000);
    tbl[3]  = mk(0, 0, 20'h00005, 16'h0000, 0, 0, 3, 16'hAB34);
    tbl[4]  = mk(1, 0, 20'h00005, 16'hFFFF, 0, 0, 2, 16'h0000);
    tbl[5]  = mk(0, 0, 20'h00005, 16'h0000, 0, 0, 3, 16'hAB34);
    tbl[6]  = mk(1, 0, 20'h00107, 16'h5A5A, 0, 0, 3, 16'h0000);
    tbl[7]  = mk(0, 0, 20'h00007, 16'h0000, 0, 0, 3, 16'h5A5A);
    tbl[8]  = mk(1, 1, 20'h00009, 16'h0F0F, 0, 0, 3, 16'h0000);
    tbl[9]  = mk(0, 0, 20'h00009, 16'h0000, 0, 0, 3, 16'h0F0F);
    tbl[10] = mk(1, 0, 20'h00009, 16'h3300, 0, 1, 5, 16'h0000);
    tbl[11] = mk(0, 0, 20'h00009, 16'h0000, 0, 0, 5, 16'h330F);
    tbl[12] = mk(0, 0, 20'h00005, 16'h0000, 0, 0, 2, 16'h0000);
    tbl[13] = mk(1, 0, 20'h000FF, 16'h1111, 0, 0, 3, 16'h0000);
    tbl[14] = mk(0, 0, 20'hFFFFF, 16'h0000, 0, 0, 3, 16'h1111);

    last_rd = 16'h0000;
    Reset = 1'b1;
    release_strobes();
    Mem_UB = 1'b1; Mem_LB = 1'b1;
    ADDR = '0; Data_from_CPU = '0;
    #3;
    check("reset busy", Busy, 32'd0);
    check("reset valid", Data_valid, 32'd0);
    check("reset data", Data_to_CPU, 32'h0000);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;

    for (int k = 0; k < 15; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Reset during the second cycle of a read clears outputs before the next edge.
    @(posedge Clk); #1;
    Mem_CE = 1'b0; Mem_WE = 1'b1; Mem_OE = 1'b0; ADDR = 20'h00005;
    @(posedge Clk); #1;
    check("rst_rd busy_c1", Busy, 32'd1);
    @(posedge Clk); #2;
    check("rst_rd data_before", Data_to_CPU, 32'h1111);
    Reset = 1'b1;
    #1;
    check("rst_rd busy", Busy, 32'd0);
    check("rst_rd valid", Data_valid, 32'd0);
    check("rst_rd data", Data_to_CPU, 32'h0000);
    release_strobes();
    @(negedge Clk) Reset = 1'b0;
    last_rd = 16'h0000;
    run_vec(mk(0, 0, 20'h00005, 16'h0000, 0, 0, 3, 16'hAB34), "rst_rd_after");

    // Reset before a write commits leaves the array untouched.
    @(posedge Clk); #1;
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; ADDR = 20'h00007;
    Mem_UB = 1'b0; Mem_LB = 1'b0; Data_from_CPU = 16'hFFFF;
    @(posedge Clk); #1;
    check("rst_wr busy_c1", Busy, 32'd1);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wr busy", Busy, 32'd0);
    release_strobes();
    @(negedge Clk) Reset = 1'b0;
    run_vec(mk(0, 0, 20'h00007, 16'h0000, 0, 0, 3, 16'h5A5A), "rst_wr_after");

    repeat (2) @(posedge Clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/slc3_mem_responder.md
SLC3_MEM_RESPONDER -- requirements
Module: slc3_mem_responder

Interface
REQ-001 The block SHALL have the parameter DEPTH_BITS, default 8, which sets the word-address width (2^DEPTH_BITS x 16-bit words).
REQ-002 The block SHALL have the parameter READ_LAT, default 3, which sets the number of sampled read cycles per read access (legal range 2..7).
REQ-003 The block SHALL have the parameter WRITE_LAT, default 3, which sets the number of sampled write cycles before a write commits (legal range 1..7).
REQ-004 Clk  input  1  system clock; all sequential logic SHALL be clocked on the rising edge.
REQ-005 Reset  input  1  reset; asynchronous, active-high.
REQ-006 Mem_CE  input  1  chip enable, active low.
REQ-007 Mem_UB  input  1  upper byte enable, active low.
REQ-008 Mem_LB  input  1  lower byte enable, active low.
REQ-009 Mem_OE  input  1  output (read) enable, active low.
REQ-010 Mem_WE  input  1  write enable, active low.
REQ-011 ADDR  input  20  word address; only ADDR[DEPTH_BITS-1:0] SHALL be used.
REQ-012 Data_from_CPU  input  16  write data from the MDR.
REQ-013 Data_to_CPU  output  16  registered read data.
REQ-014 Data_valid  output  1  high while Data_to_CPU holds the word for the current read.
REQ-015 Busy  output  1  high while a read or write access is in progress.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RD_WAIT, RD_DONE, WR_WAIT and WR_DONE, with a 3-bit cycle counter.
REQ-017 In IDLE, an edge sampling CE=0, WE=0 SHALL capture the address and byte enables, set count=1, and go to WR_WAIT (or go directly to WR_DONE with the commit when WRITE_LAT=1).
REQ-018 In IDLE, an edge sampling CE=0, WE=1, OE=0 SHALL capture the address, set count=1, and go to RD_WAIT.
REQ-019 When OE and WE are sampled low together, the write SHALL take priority and no read SHALL occur.
REQ-020 In RD_WAIT, each edge with CE=0, OE=0 SHALL increment count.
REQ-021 At the edge where count reaches READ_LAT-1, the block SHALL load Data_to_CPU with mem[captured addr], set Data_valid=1, and go to RD_DONE.
- With default parameters, data is therefore valid during the 3rd OE-low cycle.
REQ-022 In RD_WAIT, an edge with OE=1 or CE=1 SHALL abort the read: return to IDLE, Data_valid=0, Data_to_CPU unchanged.
REQ-023 RD_DONE SHALL hold Data_valid=1 until an edge samples OE=1 or CE=1, then go to IDLE with Data_valid=0; Data_to_CPU SHALL hold its last value.
REQ-024 In WR_WAIT, each edge with CE=0, WE=0 SHALL increment count.
REQ-025 At the WRITE_LAT-th sampled edge, the block SHALL write Data_from_CPU[15:8] if captured UB=0 and Data_from_CPU[7:0] if captured LB=0, then go to WR_DONE; the write data used SHALL be the value present at the commit edge.
REQ-026 In WR_WAIT, an edge with WE=1 or CE=1 before commit SHALL abort: no memory change, return to IDLE.
REQ-027 WR_DONE SHALL perform exactly one write per access; it SHALL return to IDLE only on an edge sampling WE=1 or CE=1.
REQ-028 Changes to ADDR, UB or LB after the capture edge SHALL be ignored until the FSM returns to IDLE.
REQ-029 Addresses SHALL alias modulo 2^DEPTH_BITS; there SHALL be no out-of-range error.
REQ-030 Busy SHALL be 1 in RD_WAIT and WR_WAIT and 0 in all other states.
REQ-031 A new access SHALL be accepted only from IDLE, so back-to-back accesses require at least one edge with the strobes released.

Reset
REQ-032 Reset=1 SHALL immediately force state=IDLE, count=0, Data_to_CPU=16'h0000, Data_valid=0 and Busy=0, independent of Clk.
REQ-033 Reset SHALL NOT clear the memory array; array contents are undefined until written.
REQ-034 A Reset asserted before a write commits SHALL leave the memory unchanged.
REQ-035 After Reset deasserts, the first access SHALL be sampled no earlier than the next rising edge.

Verification
REQ-036 Full write then read: write 16'hABCD to addr 5 with UB=LB=0 and WE low 3 cycles, then hold OE low 3 cycles -> Data_to_CPU=16'hABCD with Data_valid=1 in the 3rd cycle, and Busy=1 in cycles 1-2.
REQ-037 Byte write: after REQ-036, write 16'h1234 to addr 5 with UB=1, LB=0 -> a read of addr 5 returns 16'hAB34.
REQ-038 Aborted write: WE low for only 2 cycles with data 16'hFFFF to addr 5 -> a read of addr 5 returns 16'hAB34.
REQ-039 Aliasing: write 16'h5A5A to ADDR=20'h00107 (DEPTH_BITS=8) -> a read of ADDR=20'h00007 returns 16'h5A5A.
REQ-040 Reset mid-access: assert Reset during cycle 2 of a read -> Data_valid=0, Busy=0 and Data_to_CPU=0 before the next edge; a following read completes normally.
REQ-041 Write priority: OE=0 and WE=0 together for 3 cycles with data 16'h0F0F to addr 9 -> Data_valid stays 0, and a later read of addr 9 returns 16'h0F0F.
